// File: rtl/cache_bridge_pkg.sv
// Shared encodings for the cache-to-AXI3 bridge: FSM states, AXI IDs,
// size codes and the captured data-side request record.
package cache_bridge_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AWW  = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // One pending data-side request as captured on call_begin
  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } data_req_t;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Write-lane steering: byte strobes from size and the low address bits,
// and the store data moved from the low bits onto its byte lanes.
module axi_wstrb_gen
  import cache_bridge_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out
);

  // Strobe pattern per access size; unknown sizes fall back to a full word
  always_comb begin
    wstrb = 4'hF;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      default:   wstrb = 4'hF;
    endcase
  end

  // Misaligned half/word accesses are not corrected, only shifted
  assign wdata_out = wdata_in << {addr_lo, 3'b000};

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridge from inst_cache / data_cache call_begin requests to single-beat
// AXI3 transactions. One pending request per cache, one transaction in
// flight, data side wins arbitration.
// Optional macro BRIDGE_TIMEOUT_EN adds a per-transaction watchdog, a sticky
// bus_error flag and draining of stray R/B beats while idle.
module cache_axi_bridge
  import cache_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  // inst_cache side
  input  logic        inst_interface_call_begin,
  input  logic [31:0] inst_interface_addr,
  output logic        inst_interface_return_ready,
  output logic [31:0] inst_interface_rdata,
  // data_cache side
  input  logic        data_interface_call_begin,
  input  logic        data_interface_enable,
  input  logic        write_enable,
  input  logic [2:0]  read_size,
  input  logic [2:0]  write_size,
  input  logic [31:0] data_interface_raddr,
  input  logic [31:0] data_interface_waddr,
  input  logic [31:0] data_interface_wdata,
  output logic        data_interface_return_ready,
  output logic [31:0] data_interface_rdata,
  // AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bus_error
);

  logic [2:0]  state;
  logic        grant_data;
  logic        inst_pend;
  logic [31:0] inst_addr_q;
  logic        data_pend;
  data_req_t   data_q;
  logic [3:0]  strb_gen;
  logic [31:0] wdata_gen;
  logic        aw_fin, w_fin, advance, wd_fire;

  // Response fields, IDs and last flags carry nothing the caches need
  logic unused_ok;
  assign unused_ok = ^{TIMEOUT_CYCLES, rid, rresp, rlast, bid, bresp};

  axi_wstrb_gen u_wstrb (
    .size      (data_q.size),
    .addr_lo   (data_q.addr[1:0]),
    .wdata_in  (data_q.wdata),
    .wstrb     (strb_gen),
    .wdata_out (wdata_gen)
  );

  assign arlen   = 4'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 4'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = wvalid;

  assign inst_interface_return_ready = (state == ST_RESP) && !grant_data;
  assign data_interface_return_ready = (state == ST_RESP) &&  grant_data;

  // A channel counts as finished once its valid has dropped or handshakes now
  assign aw_fin = !awvalid || awready;
  assign w_fin  = !wvalid  || wready;

  // Handshake that moves the FSM out of a waiting state this cycle
  always_comb begin
    advance = 1'b0;
    case (state)
      ST_AR:   advance = arready;
      ST_R:    advance = rvalid;
      ST_AWW:  advance = aw_fin && w_fin;
      ST_B:    advance = bvalid;
      default: advance = 1'b0;
    endcase
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             busy;
  logic             drain_arm;
  logic             bus_error_q;

  assign busy    = (state == ST_AR) || (state == ST_R) || (state == ST_AWW) || (state == ST_B);
  assign wd_fire = busy && !advance && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every state change and whenever the bridge is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wd_cnt <= '0;
    else if (!busy || advance || wd_fire) wd_cnt <= '0;
    else                                wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky error flag; drain_arm keeps the idle rready/bready low during reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_error_q <= 1'b0;
      drain_arm   <= 1'b0;
    end else begin
      drain_arm <= 1'b1;
      if (wd_fire) bus_error_q <= 1'b1;
    end
  end

  assign bus_error = bus_error_q;
  assign rready    = (state == ST_R) || (drain_arm && state == ST_IDLE);
  assign bready    = (state == ST_B) || (drain_arm && state == ST_IDLE);
`else
  assign wd_fire   = 1'b0;
  assign bus_error = 1'b0;
  assign rready    = (state == ST_R);
  assign bready    = (state == ST_B);
`endif

  // Request capture, arbitration and the AXI transaction sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= ST_IDLE;
      grant_data           <= 1'b0;
      inst_pend            <= 1'b0;
      inst_addr_q          <= '0;
      data_pend            <= 1'b0;
      data_q               <= '0;
      arvalid              <= 1'b0;
      araddr               <= '0;
      arid                 <= '0;
      arsize               <= '0;
      awvalid              <= 1'b0;
      awaddr               <= '0;
      awid                 <= '0;
      awsize               <= '0;
      wvalid               <= 1'b0;
      wdata                <= '0;
      wstrb                <= '0;
      wid                  <= '0;
      inst_interface_rdata <= '0;
      data_interface_rdata <= '0;
    end else begin
      if (inst_interface_call_begin && !inst_pend) begin
        inst_pend   <= 1'b1;
        inst_addr_q <= inst_interface_addr;
      end
      if (data_interface_call_begin && data_interface_enable && !data_pend) begin
        data_pend    <= 1'b1;
        data_q.we    <= write_enable;
        data_q.size  <= write_enable ? write_size : read_size;
        data_q.addr  <= write_enable ? data_interface_waddr : data_interface_raddr;
        data_q.wdata <= data_interface_wdata;
      end

      case (state)
        ST_IDLE: begin
          if (data_pend) begin
            grant_data <= 1'b1;
            if (data_q.we) begin
              state   <= ST_AWW;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= data_q.addr;
              awsize  <= data_q.size;
              awid    <= AXI_ID_DATA;
              wid     <= AXI_ID_DATA;
              wdata   <= wdata_gen;
              wstrb   <= strb_gen;
            end else begin
              state   <= ST_AR;
              arvalid <= 1'b1;
              araddr  <= data_q.addr;
              arsize  <= data_q.size;
              arid    <= AXI_ID_DATA;
            end
          end else if (inst_pend) begin
            grant_data <= 1'b0;
            state      <= ST_AR;
            arvalid    <= 1'b1;
            araddr     <= inst_addr_q;
            arsize     <= SIZE_WORD;
            arid       <= AXI_ID_INST;
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            if (grant_data) data_interface_rdata <= rdata;
            else            inst_interface_rdata <= rdata;
            state <= ST_RESP;
          end
        end
        ST_AWW: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_fin && w_fin) state <= ST_B;
        end
        ST_B: begin
          if (bvalid) state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (grant_data) data_pend <= 1'b0;
          else            inst_pend <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Watchdog abort overrides whatever the waiting state decided
      if (wd_fire) begin
        arvalid <= 1'b0;
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        state   <= ST_RESP;
        if (grant_data) data_interface_rdata <= '0;
        else            inst_interface_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: a simple AXI slave with per-test
// ready delays, an expectation model built from the request stream, and one
// negedge compare process checking every handshake and return pulse.
module tb_cache_axi_bridge;

  localparam int K_AR  = 0;
  localparam int K_RET = 1;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [3:0]  id;
    logic [3:0]  strb;
    bit          chk;
  } ev_t;

  logic        clk, reset;
  logic        inst_interface_call_begin;
  logic [31:0] inst_interface_addr;
  logic        inst_interface_return_ready;
  logic [31:0] inst_interface_rdata;
  logic        data_interface_call_begin, data_interface_enable, write_enable;
  logic [2:0]  read_size, write_size;
  logic [31:0] data_interface_raddr, data_interface_waddr, data_interface_wdata;
  logic        data_interface_return_ready;
  logic [31:0] data_interface_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready, bus_error;

  cache_axi_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .inst_interface_call_begin(inst_interface_call_begin),
    .inst_interface_addr(inst_interface_addr),
    .inst_interface_return_ready(inst_interface_return_ready),
    .inst_interface_rdata(inst_interface_rdata),
    .data_interface_call_begin(data_interface_call_begin),
    .data_interface_enable(data_interface_enable),
    .write_enable(write_enable), .read_size(read_size), .write_size(write_size),
    .data_interface_raddr(data_interface_raddr), .data_interface_waddr(data_interface_waddr),
    .data_interface_wdata(data_interface_wdata),
    .data_interface_return_ready(data_interface_return_ready),
    .data_interface_rdata(data_interface_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  ev_t ev_q[$], aw_q[$], w_q[$];
  logic [31:0] mem [logic [31:0]];
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  bit ar_block = 0;
  int ar_hs = 0, aw_hs = 0, inst_ret = 0, data_ret = 0, arv_hi = 0;
  logic [31:0] last_araddr, last_inst_rdata, last_wdata;
  logic [3:0]  last_arid, last_wstrb;
  logic [2:0]  last_arsize;
  logic        exp_berr = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Model of the write lanes: 2^size bytes placed at the size-aligned offset
  function automatic logic [3:0] exp_strb(input logic [2:0] sz, input logic [31:0] a);
    int nbytes = (sz >= 3'd2) ? 4 : (1 << sz);
    int off = (int'(a % 4) / nbytes) * nbytes;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  function automatic void exp_ar(input logic [31:0] a, input logic [2:0] sz, input logic [3:0] id);
    ev_t e;
    e.kind = K_AR; e.a = a; e.sz = sz; e.id = id; e.strb = 4'h0; e.chk = 1'b1;
    ev_q.push_back(e);
  endfunction

  function automatic void exp_ret(input logic [3:0] side, input logic [31:0] d, input bit chk);
    ev_t e;
    e.kind = K_RET; e.a = d; e.sz = 3'd0; e.id = side; e.strb = 4'h0; e.chk = chk;
    ev_q.push_back(e);
  endfunction

  // A load: AR then a return pulse carrying the slave word
  function automatic void exp_load(input bit is_data, input logic [31:0] a, input logic [2:0] sz);
    exp_ar(a, is_data ? sz : 3'd2, is_data ? 4'd1 : 4'd0);
    exp_ret(is_data ? 4'd1 : 4'd0, mem_rd(a), 1'b1);
  endfunction

  function automatic void exp_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    ev_t e;
    e.kind = K_AR; e.a = a; e.sz = sz; e.id = 4'd1; e.strb = 4'h0; e.chk = 1'b1;
    aw_q.push_back(e);
    e.a = 32'(wd * (64'd1 << (8 * (a % 4)))); e.strb = exp_strb(sz, a);
    w_q.push_back(e);
    exp_ret(4'd1, 32'h0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic inst_pulse(input logic [31:0] a);
    inst_interface_call_begin = 1'b1; inst_interface_addr = a;
    tick();
    inst_interface_call_begin = 1'b0;
  endtask

  task automatic set_data(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    data_interface_call_begin = 1'b1; data_interface_enable = 1'b1; write_enable = we;
    read_size = sz; write_size = sz; data_interface_raddr = a; data_interface_waddr = a;
    data_interface_wdata = wd;
  endtask

  task automatic data_pulse(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    set_data(we, sz, a, wd);
    tick();
    data_interface_call_begin = 1'b0; data_interface_enable = 1'b0;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    nchk++;
    if ({arvalid, rready, awvalid, wvalid, wlast, bready, inst_interface_return_ready,
         data_interface_return_ready, bus_error, arid, awid, wid, arsize, awsize, wstrb} !== '0 ||
        araddr !== '0 || awaddr !== '0 || wdata !== '0 ||
        inst_interface_rdata !== '0 || data_interface_rdata !== '0) begin
      nfail++;
      $display("FAIL %s: outputs not zero arv=%b awv=%b wv=%b rr=%b br=%b araddr=%h awaddr=%h wdata=%h irdata=%h drdata=%h",
               name, arvalid, awvalid, wvalid, rready, bready, araddr, awaddr, wdata,
               inst_interface_rdata, data_interface_rdata);
    end
  endtask

  // Waits (bounded) until every expected event has been observed
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((ev_q.size() + aw_q.size() + w_q.size()) != 0 && n < budget) begin
      tick(); n++;
    end
    nchk++;
    if ((ev_q.size() + aw_q.size() + w_q.size()) != 0) begin
      nfail++;
      $display("FAIL %s: %0d expected events still pending after %0d cycles", name,
               ev_q.size() + aw_q.size() + w_q.size(), budget);
      ev_q.delete(); aw_q.delete(); w_q.delete();
    end
    repeat (4) tick();
  endtask

  // Read slave: arready after ar_delay, one R beat after r_delay
  initial begin : ar_slave
    logic [31:0] a_l;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
    forever begin
      tick();
      if (!reset && arvalid && !ar_block) begin
        repeat (ar_delay) tick();
        arready = 1'b1; a_l = araddr; rid = arid;
        tick();
        arready = 1'b0;
        repeat (r_delay) tick();
        rdata = mem_rd(a_l); rvalid = 1'b1; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
      end
    end
  end

  // Write slave: independent AW/W ready delays, B once both have been accepted
  initial begin : w_slave
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    forever begin
      tick();
      if (!reset && (awvalid || wvalid)) begin
        fork
          begin repeat (aw_delay) tick(); awready = 1'b1; tick(); awready = 1'b0; end
          begin repeat (w_delay) tick(); wready = 1'b1; tick(); wready = 1'b0; end
        join
        repeat (b_delay) tick();
        bvalid = 1'b1; bid = 4'd1;
        tick();
        bvalid = 1'b0;
      end
    end
  end

  // Compare process: every handshake and return pulse against the model
  initial begin : compare
    ev_t e;
    logic [31:0] rd;
    bit side_ok;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (arvalid) arv_hi++;
        if (arvalid && arready) begin
          ar_hs++; last_araddr = araddr; last_arid = arid; last_arsize = arsize;
          nchk++;
          if (ev_q.size() == 0 || ev_q[0].kind != K_AR) begin
            nfail++;
            $display("FAIL ar_order: got AR addr %h id %0d, expected no AR now", araddr, arid);
          end else begin
            e = ev_q.pop_front();
            if (araddr !== e.a || arsize !== e.sz || arid !== e.id || arlen !== 4'd0 || arburst !== 2'b01) begin
              nfail++;
              $display("FAIL ar_fields: got addr %h size %0d id %0d len %0d burst %0d, expected addr %h size %0d id %0d len 0 burst 1",
                       araddr, arsize, arid, arlen, arburst, e.a, e.sz, e.id);
            end
          end
        end
        if (awvalid && awready) begin
          aw_hs++; nchk++;
          if (aw_q.size() == 0) begin
            nfail++;
            $display("FAIL aw_extra: got AW addr %h, expected none", awaddr);
          end else begin
            e = aw_q.pop_front();
            if (awaddr !== e.a || awsize !== e.sz || awid !== e.id || awlen !== 4'd0 || awburst !== 2'b01) begin
              nfail++;
              $display("FAIL aw_fields: got addr %h size %0d id %0d, expected addr %h size %0d id %0d",
                       awaddr, awsize, awid, e.a, e.sz, e.id);
            end
          end
        end
        if (wvalid && wready) begin
          last_wdata = wdata; last_wstrb = wstrb; nchk++;
          if (w_q.size() == 0) begin
            nfail++;
            $display("FAIL w_extra: got W data %h, expected none", wdata);
          end else begin
            e = w_q.pop_front();
            if (wdata !== e.a || wstrb !== e.strb || wlast !== 1'b1 || wid !== e.id) begin
              nfail++;
              $display("FAIL w_fields: got data %h strb %b last %b id %0d, expected data %h strb %b last 1 id %0d",
                       wdata, wstrb, wlast, wid, e.a, e.strb, e.id);
            end
          end
        end
        if (inst_interface_return_ready || data_interface_return_ready) begin
          nchk++;
          if (inst_interface_return_ready) begin inst_ret++; last_inst_rdata = inst_interface_rdata; end
          if (data_interface_return_ready) data_ret++;
          if (ev_q.size() == 0 || ev_q[0].kind != K_RET) begin
            nfail++;
            $display("FAIL ret_order: got ready inst=%b data=%b, expected no return now",
                     inst_interface_return_ready, data_interface_return_ready);
          end else begin
            e = ev_q.pop_front();
            side_ok = (e.id == 4'd1) ? (data_interface_return_ready && !inst_interface_return_ready)
                                     : (inst_interface_return_ready && !data_interface_return_ready);
            rd = (e.id == 4'd1) ? data_interface_rdata : inst_interface_rdata;
            if (!side_ok || (e.chk && rd !== e.a)) begin
              nfail++;
              $display("FAIL ret_fields: got inst=%b data=%b rdata %h, expected side %0d rdata %h",
                       inst_interface_return_ready, data_interface_return_ready, rd, e.id, e.a);
            end
          end
        end
      end
    end
  end

  initial begin : main
    int base_i, base_d, base_aw, base_ar, base_hi, n;
    reset = 1'b1;
    inst_interface_call_begin = 1'b0; inst_interface_addr = '0;
    data_interface_call_begin = 1'b0; data_interface_enable = 1'b0; write_enable = 1'b0;
    read_size = '0; write_size = '0; data_interface_raddr = '0; data_interface_waddr = '0;
    data_interface_wdata = '0;
    mem[32'h0000_1000] = 32'h2402_0001;
    mem[32'h0000_1004] = 32'h0BAD_F00D;
    mem[32'h0000_3006] = 32'h5A5A_1234;
    mem[32'h0000_1010] = 32'h1111_2222;
    repeat (3) tick();
    check_zero("reset_outputs");
    @(negedge clk); reset = 1'b0;
    tick();

    // 1: single instruction fetch
    base_i = inst_ret;
    exp_load(1'b0, 32'h0000_1000, 3'd2);
    inst_pulse(32'h0000_1000);
    wait_drain("t1_drain", 40);
    chk32("t1_araddr", last_araddr, 32'h0000_1000);
    chk32("t1_arid", 32'(last_arid), 32'd0);
    chk32("t1_arsize", 32'(last_arsize), 32'd2);
    chk32("t1_rdata", last_inst_rdata, 32'h2402_0001);
    chk32("t1_pulses", 32'(inst_ret - base_i), 32'd1);

    // 2: simultaneous inst + data load, data first
    ar_delay = 1;
    exp_load(1'b1, 32'h0000_3006, 3'd1);
    exp_load(1'b0, 32'h0000_1004, 3'd2);
    inst_interface_call_begin = 1'b1; inst_interface_addr = 32'h0000_1004;
    set_data(1'b0, 3'd1, 32'h0000_3006, 32'h0);
    tick();
    inst_interface_call_begin = 1'b0; data_interface_call_begin = 1'b0; data_interface_enable = 1'b0;
    wait_drain("t2_drain", 60);
    ar_delay = 0;

    // 3: sb at 0x2003, awready late
    aw_delay = 3; w_delay = 0;
    base_d = data_ret;
    exp_store(32'h0000_2003, 3'd0, 32'h0000_00AB);
    data_pulse(1'b1, 3'd0, 32'h0000_2003, 32'h0000_00AB);
    wait_drain("t3_drain", 40);
    chk32("t3_wstrb", 32'(last_wstrb), 32'h8);
    chk32("t3_wdata", last_wdata, 32'hAB00_0000);
    chk32("t3_pulses", 32'(data_ret - base_d), 32'd1);

    // 4: sh at 0x2002, W accepted before AW
    aw_delay = 2; w_delay = 0;
    base_aw = aw_hs;
    exp_store(32'h0000_2002, 3'd1, 32'h0000_1234);
    data_pulse(1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234);
    wait_drain("t4_drain", 40);
    chk32("t4_wstrb", 32'(last_wstrb), 32'hC);
    chk32("t4_wdata", last_wdata, 32'h1234_0000);
    chk32("t4_aw_count", 32'(aw_hs - base_aw), 32'd1);

    // Extra lane patterns: word store with both readies together, sb at offset 1
    aw_delay = 0; w_delay = 0; b_delay = 2;
    exp_store(32'h0000_2000, 3'd2, 32'hCAFE_BABE);
    data_pulse(1'b1, 3'd2, 32'h0000_2000, 32'hCAFE_BABE);
    wait_drain("sw_drain", 40);
    chk32("sw_wstrb", 32'(last_wstrb), 32'hF);
    exp_store(32'h0000_2001, 3'd0, 32'h0000_00AB);
    data_pulse(1'b1, 3'd0, 32'h0000_2001, 32'h0000_00AB);
    wait_drain("sb1_drain", 40);
    chk32("sb1_wdata", last_wdata, 32'h0000_AB00);
    b_delay = 0;

    // 5: async reset while waiting in R
    r_delay = 6;
    base_ar = ar_hs;
    exp_ar(32'h0000_1010, 3'd2, 4'd0);
    inst_pulse(32'h0000_1010);
    n = 0;
    while (ar_hs == base_ar && n < 20) begin tick(); n++; end
    chk32("t5_ar_seen", 32'(ar_hs - base_ar), 32'd1);
    @(negedge clk); reset = 1'b1; #1;
    check_zero("t5_reset_outputs");
    repeat (2) tick();
    @(negedge clk); reset = 1'b0;
    base_i = inst_ret; base_ar = ar_hs;
    repeat (20) tick();
    chk32("t5_no_ret", 32'(inst_ret - base_i), 32'd0);
    chk32("t5_no_new_ar", 32'(ar_hs - base_ar), 32'd0);
    chk32("t5_arvalid", 32'(arvalid), 32'd0);
    ev_q.delete();
    r_delay = 0;

`ifdef BRIDGE_TIMEOUT_EN
    // 6: watchdog with arready stuck low
    ar_block = 1'b1;
    base_hi = arv_hi;
    exp_ret(4'd0, 32'h0, 1'b1);
    inst_pulse(32'h0000_1020);
    wait_drain("t6_drain", 60);
    chk32("t6_ar_cycles", 32'(arv_hi - base_hi), 32'd16);
    ar_block = 1'b0;
    exp_berr = 1'b1;
`else
    base_hi = arv_hi;
`endif
    chk32("bus_error", 32'(bus_error), 32'(exp_berr));

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
